tipi_bus_ctrl: RTL
==================

# tipi_bus_ctrl

Synchronous TI-bus sequencer for the TIPI expansion card, clocked from the 50 MHz board clock. Samples the asynchronous TI bus strobes and RPi serial lines, decodes the 0x4000–0x5FFF DSR window, sequences block-RAM ROM reads and TI register reads onto the shared output bus, and captures TI writes to the data and control registers. It owns the single bus transmitter enable and holds RPi latch updates off the bus while the TI is reading them.

## Interface
- ROM_AW, 13, ROM word-address width (8 KiB DSR image)
- SYNC_STAGES, 2, synchronizer depth for all asynchronous inputs
- clk  in  1  50 MHz board clock
- rst  in  1  reset; synchronous, active-high
- crubit  in  1  device-enable CRU bit (already in the clk domain)
- ti_a  in  16  TI address [0:15], bit 0 is MSB (asynchronous)
- ti_data  in  8  TI data [0:7], bit 0 is MSB (asynchronous)
- ti_memen, ti_we, ti_dbin  in  1 each  TI strobes: memen and we active-low, dbin active-high (asynchronous)
- rpi_cclk, rpi_dclk, rpi_sdata, rpi_le  in  1 each  RPi serial control clock, data clock, data, latch enable (asynchronous)
- rom_addr  out  ROM_AW  block-RAM address
- rom_q  in  8  block-RAM data, valid 2 clk after rom_addr changes
- bus_d  out  8  data presented to the TI bus transmitter [0:7]
- bus_oe_n  out  1  transmitter enable, active-low
- td_q, tc_q  out  8 each  TI-written data (0x5FFF) and control (0x5FFD) registers
- rd_latch, rc_latch  out  8 each  RPi-supplied data and control registers
- td_stb, tc_stb  out  1 each  one-clk pulse when td_q / tc_q is written

## Operation
- All asynchronous inputs pass through SYNC_STAGES flops. ti_a and ti_data are sampled together with the strobes; decoding uses only synchronized copies.
- Read FSM states: IDLE, DECODE, ROM_WAIT, DRIVE, RELEASE.
  - IDLE -> DECODE on the synchronized falling edge of memen with dbin=1 and crubit=1.
  - DECODE selects a source: 0x5FFB -> rd_latch; 0x5FF9 -> rc_latch; 0x4000–0x5FF7 -> ROM; any other address -> back to IDLE, bus untouched. For ROM, rom_addr <= ti_a[3:15].
  - ROM_WAIT lasts 2 clk for ROM, 0 clk for register reads.
  - DRIVE loads bus_d and asserts bus_oe_n=0. It holds until synchronized memen=1 or dbin=0, then goes to RELEASE.
  - RELEASE deasserts bus_oe_n, returns to IDLE next clk, and leaves bus_d unchanged.
- Write capture: on the synchronized falling edge of we with memen=0 and crubit=1:
  - 0x5FFF -> td_q <= ti_data, pulse td_stb.
  - 0x5FFD -> tc_q <= ti_data, pulse tc_stb.
  - Writes to other addresses are ignored. Writes never enter the read FSM.
- RPi shifting:
  - On each synchronized rising edge of rpi_dclk: if le=0, data shifter <= {shifter[6:0], sdata}; if le=1, request a copy of the shifter into rd_latch.
  - rpi_cclk does the same for the control shifter and rc_latch.
- Latch arbitration: a copy request for a latch the FSM is currently sourcing (DECODE through RELEASE) is held pending. It is applied in the clk after the FSM returns to IDLE. A newer request overwrites a pending one (the latest shifter value wins).
- If crubit falls mid-cycle, the FSM goes straight to RELEASE.
- Reset clears all outputs, shifters, pending flags and synchronizers. FSM goes to IDLE, bus_oe_n=1, and all data outputs are 0.

## Timing
- Read latency from raw memen fall to bus_oe_n=0:
  - register read: SYNC_STAGES+2 clk (80 ns at defaults);
  - ROM read: SYNC_STAGES+4 clk (120 ns).
  - Both are well inside the TI read window.
- bus_d is stable before bus_oe_n falls and does not change while bus_oe_n=0.
- bus_oe_n rises SYNC_STAGES+1 clk after the raw memen rise.
- td_q/tc_q update SYNC_STAGES+1 clk after the raw we fall; td_stb/tc_stb are high exactly 1 clk.
- A write and a read-cycle start in the same clk cannot both be valid (dbin and we are exclusive). If both are seen, the write wins and the read is ignored.
- RPi edges closer than 3 clk apart are not guaranteed to be captured (RPi shift clock must be ≤ 8 MHz).

## Structure
- Shared package tipi_pkg holds:
  - address constants DSR_LO=16'h4000, DSR_HI=16'h5FF7, A_RDATA=16'h5FFB, A_RCTRL=16'h5FF9, A_TDATA=16'h5FFF, A_TCTRL=16'h5FFD;
  - the read-FSM state enum.
- One sub-module, tipi_rpi_shifter, is instantiated twice (data and control). It contains the synchronizer, edge detect, 8-bit shifter, latch and pending logic, and takes a hold input from the FSM.

## Test plan
- Reset, then crubit=1 and a read of 0x4000 with ROM word 0 = 0xAA -> bus_oe_n=0 within 6 clk of memen fall; bus_d=0xAA until memen rises; bus_oe_n=1 3 clk after memen rises.
- Write 0x5FFF with data 0x3C -> td_q=0x3C, one td_stb pulse, tc_q unchanged. Repeat with crubit=0 -> no change.
- RPi shifts 0xA5 MSB-first on dclk, then pulses le -> rd_latch=0xA5. A TI read of 0x5FFB then returns 0xA5.
- During a 0x5FFB read holding 0x11, the RPi latches 0x22 -> bus_d stays 0x11 through DRIVE; rd_latch=0x22 1 clk after IDLE.
- Read 0x5FF8 and 0x6000 -> bus_oe_n stays 1 and the FSM returns to IDLE.
- Assert rst during DRIVE -> next clk bus_oe_n=1, all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/tipi_pkg.sv
// Shared constants, read-FSM state and read-source encodings for the TIPI bus sequencer.
package tipi_pkg;

    localparam logic [15:0] DSR_LO  = 16'h4000;
    localparam logic [15:0] DSR_HI  = 16'h5FF7;
    localparam logic [15:0] A_RDATA = 16'h5FFB;
    localparam logic [15:0] A_RCTRL = 16'h5FF9;
    localparam logic [15:0] A_TDATA = 16'h5FFF;
    localparam logic [15:0] A_TCTRL = 16'h5FFD;

    localparam int unsigned ROM_WAIT_CLKS = 2;
    localparam int unsigned TI_AW         = 16;
    localparam int unsigned TI_DW         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ROM_WAIT,
        ST_DRIVE,
        ST_RELEASE
    } rd_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ROM,
        SRC_RDATA,
        SRC_RCTRL
    } rd_src_e;

    // Map a TI read address onto the source that answers it.
    function automatic rd_src_e decode_src(input logic [15:0] a);
        rd_src_e src;
        src = SRC_NONE;
        if (a == A_RDATA) begin
            src = SRC_RDATA;
        end else if (a == A_RCTRL) begin
            src = SRC_RCTRL;
        end else if ((a >= DSR_LO) && (a <= DSR_HI)) begin
            src = SRC_ROM;
        end
        return src;
    endfunction

endpackage

// File: rtl/tipi_rpi_shifter.sv
// One RPi serial channel: synchronizer, shift-clock edge detect, 8-bit shifter and
// an output latch whose update is deferred while the read FSM is sourcing it.
module tipi_rpi_shifter
    import tipi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sdata,
    input  logic       le,
    input  logic       hold,
    output logic [7:0] latch
);

    localparam int unsigned SW = 3;

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic          sclk_s;
    logic          sdata_s;
    logic          le_s;
    logic          sclk_d;
    logic          rise;
    logic [7:0]    shift_q;
    logic [7:0]    pend_val;
    logic          pend;

    assign {sclk_s, sdata_s, le_s} = sync_q[SYNC_STAGES-1];
    assign rise = sclk_s & ~sclk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {sclk, sdata, le};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A copy request while held parks the shifter value; a later request replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d   <= 1'b0;
            shift_q  <= 8'h00;
            pend     <= 1'b0;
            pend_val <= 8'h00;
            latch    <= 8'h00;
        end else begin
            sclk_d <= sclk_s;
            if (rise && !le_s) begin
                shift_q <= {shift_q[6:0], sdata_s};
            end
            if (rise && le_s) begin
                if (hold) begin
                    pend     <= 1'b1;
                    pend_val <= shift_q;
                end else begin
                    latch <= shift_q;
                    pend  <= 1'b0;
                end
            end else if (pend && !hold) begin
                latch <= pend_val;
                pend  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tipi_bus_ctrl.sv
// TI-bus sequencer: DSR-window read FSM, TI register write capture and RPi latches.
// TI buses use MSB-first numbering; here bit 15 of ti_a is TI A0 and bit 7 of ti_data is D0.
module tipi_bus_ctrl
    import tipi_pkg::*;
#(
    parameter int unsigned ROM_AW      = 13,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              crubit,
    input  logic [15:0]       ti_a,
    input  logic [7:0]        ti_data,
    input  logic              ti_memen,
    input  logic              ti_we,
    input  logic              ti_dbin,
    input  logic              rpi_cclk,
    input  logic              rpi_dclk,
    input  logic              rpi_sdata,
    input  logic              rpi_le,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic [7:0]        bus_d,
    output logic              bus_oe_n,
    output logic [7:0]        td_q,
    output logic [7:0]        tc_q,
    output logic [7:0]        rd_latch,
    output logic [7:0]        rc_latch,
    output logic              td_stb,
    output logic              tc_stb
);

    localparam int unsigned TI_SW = TI_AW + TI_DW + 3;

    logic [TI_SW-1:0] ti_sync [SYNC_STAGES];
    logic [15:0]      a_s;
    logic [7:0]       data_s;
    logic             memen_s;
    logic             we_s;
    logic             dbin_s;
    logic             memen_d;
    logic             we_d;
    logic             wr_start;
    logic             rd_start;
    logic             hold_rd;
    logic             hold_rc;
    rd_state_e        state;
    rd_src_e          src;
    logic [1:0]       wait_cnt;

    assign {a_s, data_s, memen_s, we_s, dbin_s} = ti_sync[SYNC_STAGES-1];

    // Address, data and strobes share one synchronizer so they stay cycle-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                ti_sync[i] <= '0;
            end
            memen_d <= 1'b0;
            we_d    <= 1'b0;
        end else begin
            ti_sync[0] <= {ti_a, ti_data, ti_memen, ti_we, ti_dbin};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                ti_sync[i] <= ti_sync[i-1];
            end
            memen_d <= memen_s;
            we_d    <= we_s;
        end
    end

    // A write seen in the same clk as a read start takes priority.
    assign wr_start = we_d & ~we_s & ~memen_s & crubit;
    assign rd_start = memen_d & ~memen_s & dbin_s & crubit & ~wr_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            td_q   <= 8'h00;
            tc_q   <= 8'h00;
            td_stb <= 1'b0;
            tc_stb <= 1'b0;
        end else begin
            td_stb <= 1'b0;
            tc_stb <= 1'b0;
            if (wr_start && (a_s == A_TDATA)) begin
                td_q   <= data_s;
                td_stb <= 1'b1;
            end
            if (wr_start && (a_s == A_TCTRL)) begin
                tc_q   <= data_s;
                tc_stb <= 1'b1;
            end
        end
    end

    // rom_addr is loaded at cycle start so the block RAM has settled by the end of ROM_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            src      <= SRC_NONE;
            wait_cnt <= 2'd0;
            rom_addr <= '0;
            bus_d    <= 8'h00;
            bus_oe_n <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        state    <= ST_DECODE;
                        src      <= decode_src(a_s);
                        rom_addr <= a_s[ROM_AW-1:0];
                    end
                end
                ST_DECODE: begin
                    if (!crubit) begin
                        state <= ST_RELEASE;
                    end else begin
                        case (src)
                            SRC_ROM: begin
                                state    <= ST_ROM_WAIT;
                                wait_cnt <= 2'(ROM_WAIT_CLKS - 1);
                            end
                            SRC_RDATA: begin
                                state    <= ST_DRIVE;
                                bus_d    <= rd_latch;
                                bus_oe_n <= 1'b0;
                            end
                            SRC_RCTRL: begin
                                state    <= ST_DRIVE;
                                bus_d    <= rc_latch;
                                bus_oe_n <= 1'b0;
                            end
                            default: begin
                                state <= ST_IDLE;
                                src   <= SRC_NONE;
                            end
                        endcase
                    end
                end
                ST_ROM_WAIT: begin
                    if (!crubit) begin
                        state <= ST_RELEASE;
                    end else if (wait_cnt == 2'd0) begin
                        state    <= ST_DRIVE;
                        bus_d    <= rom_q;
                        bus_oe_n <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_DRIVE: begin
                    if (!crubit || memen_s || !dbin_s) begin
                        state    <= ST_RELEASE;
                        bus_oe_n <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state    <= ST_IDLE;
                    src      <= SRC_NONE;
                    bus_oe_n <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    src      <= SRC_NONE;
                    bus_oe_n <= 1'b1;
                end
            endcase
        end
    end

    assign hold_rd = (state != ST_IDLE) && (src == SRC_RDATA);
    assign hold_rc = (state != ST_IDLE) && (src == SRC_RCTRL);

    tipi_rpi_shifter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_data_shifter (
        .clk  (clk),
        .rst  (rst),
        .sclk (rpi_dclk),
        .sdata(rpi_sdata),
        .le   (rpi_le),
        .hold (hold_rd),
        .latch(rd_latch)
    );

    tipi_rpi_shifter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ctrl_shifter (
        .clk  (clk),
        .rst  (rst),
        .sclk (rpi_cclk),
        .sdata(rpi_sdata),
        .le   (rpi_le),
        .hold (hold_rc),
        .latch(rc_latch)
    );

endmodule
